sha256_comp_ctrl: RTL and testbench

- Sequencer and compression engine for single-block SHA-256 (message ≤55 bytes).
- On a go request it pulses the padder's go input, waits for the W-schedule generator's ready, then reads W[0..63] from that generator's read port.
- Runs the 64 compression rounds, adds the initial hash values, and writes the eight 32-bit digest words to the hash output SRAM.
- Sits between the top-level go/finish handshake and the gen_padded → gen_w_less chain.

---
 rtl/sha256_pkg.sv | 55 +++++
 rtl/sha256_k_rom.sv | 48 ++++
 rtl/sha256_comp_ctrl.sv | 139 +++++++++++++
 tb/tb_sha256_comp_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state encoding, initial hash words
// and the round-function primitives.
package sha256_pkg;

  localparam int W_IDX_WIDTH = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_W,
    ST_PRIME,
    ST_ROUND,
    ST_FINAL,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic [31:0] h_init(input logic [2:0] idx);
    logic [31:0] h;
    case (idx)
      3'd0:    h = 32'h6a09e667;
      3'd1:    h = 32'hbb67ae85;
      3'd2:    h = 32'h3c6ef372;
      3'd3:    h = 32'ha54ff53a;
      3'd4:    h = 32'h510e527f;
      3'd5:    h = 32'h9b05688c;
      3'd6:    h = 32'h1f83d9ab;
      default: h = 32'h5be0cd19;
    endcase
    return h;
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// SHA-256 round constants K[0..63], combinational lookup by round index.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [W_IDX_WIDTH-1:0] idx,
  output logic [31:0]            k_word
);

  always_comb begin
    k_word = 32'h0;
    case (idx)
      6'd0:  k_word = 32'h428a2f98;  6'd1:  k_word = 32'h71374491;
      6'd2:  k_word = 32'hb5c0fbcf;  6'd3:  k_word = 32'he9b5dba5;
      6'd4:  k_word = 32'h3956c25b;  6'd5:  k_word = 32'h59f111f1;
      6'd6:  k_word = 32'h923f82a4;  6'd7:  k_word = 32'hab1c5ed5;
      6'd8:  k_word = 32'hd807aa98;  6'd9:  k_word = 32'h12835b01;
      6'd10: k_word = 32'h243185be;  6'd11: k_word = 32'h550c7dc3;
      6'd12: k_word = 32'h72be5d74;  6'd13: k_word = 32'h80deb1fe;
      6'd14: k_word = 32'h9bdc06a7;  6'd15: k_word = 32'hc19bf174;
      6'd16: k_word = 32'he49b69c1;  6'd17: k_word = 32'hefbe4786;
      6'd18: k_word = 32'h0fc19dc6;  6'd19: k_word = 32'h240ca1cc;
      6'd20: k_word = 32'h2de92c6f;  6'd21: k_word = 32'h4a7484aa;
      6'd22: k_word = 32'h5cb0a9dc;  6'd23: k_word = 32'h76f988da;
      6'd24: k_word = 32'h983e5152;  6'd25: k_word = 32'ha831c66d;
      6'd26: k_word = 32'hb00327c8;  6'd27: k_word = 32'hbf597fc7;
      6'd28: k_word = 32'hc6e00bf3;  6'd29: k_word = 32'hd5a79147;
      6'd30: k_word = 32'h06ca6351;  6'd31: k_word = 32'h14292967;
      6'd32: k_word = 32'h27b70a85;  6'd33: k_word = 32'h2e1b2138;
      6'd34: k_word = 32'h4d2c6dfc;  6'd35: k_word = 32'h53380d13;
      6'd36: k_word = 32'h650a7354;  6'd37: k_word = 32'h766a0abb;
      6'd38: k_word = 32'h81c2c92e;  6'd39: k_word = 32'h92722c85;
      6'd40: k_word = 32'ha2bfe8a1;  6'd41: k_word = 32'ha81a664b;
      6'd42: k_word = 32'hc24b8b70;  6'd43: k_word = 32'hc76c51a3;
      6'd44: k_word = 32'hd192e819;  6'd45: k_word = 32'hd6990624;
      6'd46: k_word = 32'hf40e3585;  6'd47: k_word = 32'h106aa070;
      6'd48: k_word = 32'h19a4c116;  6'd49: k_word = 32'h1e376c08;
      6'd50: k_word = 32'h2748774c;  6'd51: k_word = 32'h34b0bcb5;
      6'd52: k_word = 32'h391c0cb3;  6'd53: k_word = 32'h4ed8aa4a;
      6'd54: k_word = 32'h5b9cca4f;  6'd55: k_word = 32'h682e6ff3;
      6'd56: k_word = 32'h748f82ee;  6'd57: k_word = 32'h78a5636f;
      6'd58: k_word = 32'h84c87814;  6'd59: k_word = 32'h8cc70208;
      6'd60: k_word = 32'h90befffa;  6'd61: k_word = 32'ha4506ceb;
      6'd62: k_word = 32'hbef9a3f7;  6'd63: k_word = 32'hc67178f2;
      default: k_word = 32'h0;
    endcase
  end

endmodule

// File: rtl/sha256_comp_ctrl.sv
// Single-block SHA-256 sequencer: kicks the padder, streams W[t] from the
// schedule generator through 64 rounds, then writes the digest to the output SRAM.
module sha256_comp_ctrl
  import sha256_pkg::*;
#(
  parameter int WORD_WIDTH     = 32,
  parameter int OUT_ADDR_WIDTH = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      main_go_sig,
  output logic                      regop_pad_go,
  input  logic                      w_reg_rdy,
  output logic                      regop_w_reg_read,
  output logic [W_IDX_WIDTH-1:0]    regop_w_reg_addr,
  input  logic [WORD_WIDTH-1:0]     w_reg_data,
  output logic                      regop_out_mem_en,
  output logic                      regop_out_mem_write,
  output logic [OUT_ADDR_WIDTH-1:0] regop_out_mem_addr,
  output logic [WORD_WIDTH-1:0]     regop_out_mem_data,
  output logic                      regop_busy,
  output logic                      regop_done
);

  state_t                 state_reg;
  logic [W_IDX_WIDTH-1:0] rnd_reg;
  logic [WORD_WIDTH-1:0]  var_reg  [8];   // a..h
  logic [WORD_WIDTH-1:0]  hash_reg [8];

  logic [WORD_WIDTH-1:0]  k_word;
  logic [WORD_WIDTH-1:0]  t1_next, t2_next;
  logic [WORD_WIDTH-1:0]  round_next [8];
  logic [WORD_WIDTH-1:0]  hash_next  [8];

  sha256_k_rom u_k_rom (
    .idx    (rnd_reg),
    .k_word (k_word)
  );

  always_comb begin
    t1_next = var_reg[7] + big_sigma1(var_reg[4]) + ch(var_reg[4], var_reg[5], var_reg[6])
            + k_word + w_reg_data;
    t2_next = big_sigma0(var_reg[0]) + maj(var_reg[0], var_reg[1], var_reg[2]);
  end

  // Round shift network plus the final feed-forward add, one lane per word.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      if (gi == 0) begin : g_a
        assign round_next[gi] = t1_next + t2_next;
      end else if (gi == 4) begin : g_e
        assign round_next[gi] = var_reg[3] + t1_next;
      end else begin : g_shift
        assign round_next[gi] = var_reg[gi-1];
      end
      assign hash_next[gi] = h_init(3'(gi)) + var_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg           <= ST_IDLE;
      rnd_reg             <= '0;
      regop_pad_go        <= 1'b0;
      regop_w_reg_read    <= 1'b0;
      regop_w_reg_addr    <= '0;
      regop_out_mem_en    <= 1'b0;
      regop_out_mem_write <= 1'b0;
      regop_out_mem_addr  <= '0;
      regop_out_mem_data  <= '0;
      regop_busy          <= 1'b0;
      regop_done          <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        var_reg[i]  <= '0;
        hash_reg[i] <= '0;
      end
    end else begin
      regop_pad_go <= 1'b0;
      regop_done   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (main_go_sig) begin
            regop_pad_go <= 1'b1;
            regop_busy   <= 1'b1;
            state_reg    <= ST_START;
          end
        end
        ST_START: state_reg <= ST_WAIT_W;
        ST_WAIT_W: begin
          if (w_reg_rdy) begin
            regop_w_reg_read <= 1'b1;
            regop_w_reg_addr <= '0;
            for (int i = 0; i < 8; i++) var_reg[i] <= h_init(3'(i));
            state_reg <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          regop_w_reg_addr <= 6'd1;
          rnd_reg          <= '0;
          state_reg        <= ST_ROUND;
        end
        ST_ROUND: begin
          for (int i = 0; i < 8; i++) var_reg[i] <= round_next[i];
          // Address runs one ahead of the round; the last read goes out in round 62.
          if (regop_w_reg_addr == 6'd63) regop_w_reg_read <= 1'b0;
          else                           regop_w_reg_addr <= regop_w_reg_addr + 6'd1;
          rnd_reg <= rnd_reg + 6'd1;
          if (rnd_reg == 6'd63) state_reg <= ST_FINAL;
        end
        ST_FINAL: begin
          for (int i = 0; i < 8; i++) hash_reg[i] <= hash_next[i];
          regop_out_mem_en    <= 1'b1;
          regop_out_mem_write <= 1'b1;
          regop_out_mem_addr  <= '0;
          regop_out_mem_data  <= hash_next[0];
          state_reg           <= ST_WRITE;
        end
        ST_WRITE: begin
          if (regop_out_mem_addr == 3'd7) begin
            regop_out_mem_en    <= 1'b0;
            regop_out_mem_write <= 1'b0;
            regop_out_mem_addr  <= '0;
            regop_out_mem_data  <= '0;
            regop_busy          <= 1'b0;
            regop_done          <= 1'b1;
            state_reg           <= ST_DONE;
          end else begin
            regop_out_mem_addr <= regop_out_mem_addr + 3'd1;
            regop_out_mem_data <= hash_reg[regop_out_mem_addr + 3'd1];
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_comp_ctrl.sv
// Directed bench: a behavioural padder/W-schedule model feeds the controller
// and the written digests are compared with known SHA-256 results.
module tb_sha256_comp_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        main_go_sig = 1'b0;
  logic        regop_pad_go;
  logic        w_reg_rdy = 1'b0;
  logic        regop_w_reg_read;
  logic [5:0]  regop_w_reg_addr;
  logic [31:0] w_reg_data = 32'h0;
  logic        regop_out_mem_en;
  logic        regop_out_mem_write;
  logic [2:0]  regop_out_mem_addr;
  logic [31:0] regop_out_mem_data;
  logic        regop_busy;
  logic        regop_done;

  sha256_comp_ctrl dut (
    .clock               (clock),
    .reset               (reset),
    .main_go_sig         (main_go_sig),
    .regop_pad_go        (regop_pad_go),
    .w_reg_rdy           (w_reg_rdy),
    .regop_w_reg_read    (regop_w_reg_read),
    .regop_w_reg_addr    (regop_w_reg_addr),
    .w_reg_data          (w_reg_data),
    .regop_out_mem_en    (regop_out_mem_en),
    .regop_out_mem_write (regop_out_mem_write),
    .regop_out_mem_addr  (regop_out_mem_addr),
    .regop_out_mem_data  (regop_out_mem_data),
    .regop_busy          (regop_busy),
    .regop_done          (regop_done)
  );

  always #5 clock = ~clock;

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [439:0] MSG_ABC   = 440'h616263;
  localparam logic [439:0] MSG_EMPTY = 440'h0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] w_mem [64];
  logic [2:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [5:0]  rd_q [$];
  int          go_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Padder + message-schedule model: one 512-bit block, W[0..63].
  task automatic load_msg(input logic [439:0] msg, input int len);
    logic [7:0]  blk [64];
    logic [15:0] bits;
    logic [31:0] s0, s1;
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int i = 0; i < len; i++) blk[i] = msg[8*(len-1-i) +: 8];
    blk[len] = 8'h80;
    bits = 16'(len * 8);
    blk[62] = bits[15:8];
    blk[63] = bits[7:0];
    for (int t = 0; t < 16; t++)
      w_mem[t] = {blk[4*t], blk[4*t+1], blk[4*t+2], blk[4*t+3]};
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w_mem[t-15], 7) ^ ror(w_mem[t-15], 18) ^ (w_mem[t-15] >> 3);
      s1 = ror(w_mem[t-2], 17) ^ ror(w_mem[t-2], 19) ^ (w_mem[t-2] >> 10);
      w_mem[t] = s1 + w_mem[t-7] + s0 + w_mem[t-16];
    end
  endtask

  // Registered W read port.
  always @(posedge clock)
    if (regop_w_reg_read) w_reg_data <= w_mem[regop_w_reg_addr];

  always @(negedge clock) begin
    if (regop_out_mem_en && regop_out_mem_write) begin
      wr_addr_q.push_back(regop_out_mem_addr);
      wr_data_q.push_back(regop_out_mem_data);
    end
    if (regop_w_reg_read) rd_q.push_back(regop_w_reg_addr);
    if (regop_pad_go) go_cnt++;
  end

  function automatic logic [63:0] all_outs();
    return {17'd0, regop_pad_go, regop_w_reg_read, regop_w_reg_addr, regop_out_mem_en,
            regop_out_mem_write, regop_out_mem_addr, regop_out_mem_data, regop_busy,
            regop_done};
  endfunction

  // One run, started at a negedge. go_pulse_at / rst_at are cycle numbers
  // counted from the cycle in which w_reg_rdy is first sampled (0 = none).
  task automatic run(input string name, input logic [439:0] msg, input int len,
                     input int rdy_delay, input int go_hold, input int go_pulse_at,
                     input int rst_at, input logic [255:0] exp);
    int n;
    int lat;
    bit aborted;
    load_msg(msg, len);
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_q.delete();
    go_cnt  = 0;
    aborted = 1'b0;
    lat     = 0;
    fork
      begin
        main_go_sig = 1'b1;
        repeat (go_hold) @(negedge clock);
        main_go_sig = 1'b0;
      end
      begin
        n = 0;
        do begin @(negedge clock); n++; end while (!regop_pad_go && n < 20);
        check({name, " pad_go"}, 64'(regop_pad_go), 64'd1);
        check({name, " busy_at_go"}, 64'(regop_busy), 64'd1);
        repeat (rdy_delay) @(negedge clock);
        check({name, " no_read_before_rdy"}, 64'(rd_q.size()), 64'd0);
        w_reg_rdy = 1'b1;
        do begin
          @(negedge clock);
          lat++;
          if (lat == go_pulse_at) main_go_sig = 1'b1;
          else if (lat == go_pulse_at + 1) main_go_sig = 1'b0;
          if (lat == rst_at) begin
            reset = 1'b1;
            @(negedge clock);
            check({name, " outs_after_reset"}, all_outs(), 64'd0);
            reset   = 1'b0;
            aborted = 1'b1;
          end
        end while (!regop_done && !aborted && lat < 400);
      end
    join
    if (aborted) begin
      repeat (100) @(negedge clock);
      check({name, " no_writes_after_reset"}, 64'(wr_addr_q.size()), 64'd0);
      check({name, " idle_after_reset"}, all_outs(), 64'd0);
    end else begin
      check({name, " done_latency"}, 64'(lat), 64'd75);
      check({name, " busy_low_at_done"}, 64'(regop_busy), 64'd0);
      check({name, " write_count"}, 64'(wr_addr_q.size()), 64'd8);
      for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
        check($sformatf("%s wr_addr[%0d]", name, i), 64'(wr_addr_q[i]), 64'(i));
        check($sformatf("%s H[%0d]", name, i), 64'(wr_data_q[i]), 64'(exp[255-32*i -: 32]));
      end
      check({name, " read_count"}, 64'(rd_q.size()), 64'd64);
      for (int i = 0; i < 64 && i < rd_q.size(); i++)
        if (rd_q[i] != 6'(i)) check($sformatf("%s rd_addr[%0d]", name, i), 64'(rd_q[i]), 64'(i));
    end
    check({name, " pad_go_pulses"}, 64'(go_cnt), 64'd1);
    $display("run %s: lat=%0d writes=%0d reads=%0d", name, lat, wr_addr_q.size(), rd_q.size());
    w_reg_rdy = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_outs", all_outs(), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    run("abc",        MSG_ABC,   3, 3,   2,  0,  0,  DIG_ABC);
    // Back-to-back: go raised in the done cycle, sampled in the following IDLE.
    run("empty_b2b",  MSG_EMPTY, 0, 2,   2,  0,  0,  DIG_EMPTY);
    repeat (4) @(negedge clock);
    run("go_held20",  MSG_ABC,   3, 3,   20, 0,  0,  DIG_ABC);
    repeat (4) @(negedge clock);
    run("go_in_round", MSG_ABC,  3, 3,   2,  30, 0,  DIG_ABC);
    repeat (4) @(negedge clock);
    run("rdy_late",   MSG_ABC,   3, 200, 2,  0,  0,  DIG_ABC);
    repeat (4) @(negedge clock);
    run("reset_t30",  MSG_ABC,   3, 3,   2,  0,  32, DIG_ABC);
    repeat (2) @(negedge clock);
    run("abc_again",  MSG_ABC,   3, 3,   2,  0,  0,  DIG_ABC);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
